iob_nco_gen: RTL and testbench
==============================

# iob_nco_gen

Numerically controlled oscillator core for the NCO peripheral: consumes the fixed-point period words delivered into the output clock domain (period data plus one-cycle write strobe) and generates the divided clock output. Fractional periods are realised by a phase accumulator that stretches individual output periods by one input cycle, so the long-run average period equals the programmed value. The block sits entirely in the generated-clock domain, downstream of the CSR-to-NCO synchroniser.

## Interface
Parameters:
- PERIOD_W, 16, total period word width, fixed-point.
- FRAC_W, 8, fractional bits of the period word. Legal range is 1 ≤ FRAC_W ≤ PERIOD_W-2.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high. This is the only reset; one clock domain.
- cke_i  in  1  clock enable. When low, all state and outputs hold.
- soft_reset_i  in  1  synchronous clear, active-high.
- enable_i  in  1  run request, level-sensitive.
- period_wdata_i  in  PERIOD_W  new period: integer part I = [PERIOD_W-1:FRAC_W], fraction F = [FRAC_W-1:0].
- period_wen_i  in  1  one-cycle strobe qualifying period_wdata_i.
- clk_o  out  1  generated clock, registered.
- running_o  out  1  high while in RUN or DRAIN.
- period_o  out  PERIOD_W  active period.
- period_ack_o  out  1  one-cycle pulse when a pending period becomes active.

## Operation
- Registers:
  - pending period (P_pend) and a pend flag.
  - active period (P_act).
  - cycle counter cnt (PERIOD_W-FRAC_W+1 bits).
  - fractional accumulator acc (FRAC_W bits).
  - current period length L.
  - state.
- A write always loads P_pend and sets the pend flag. A newer write before transfer overwrites the older one; only the last value is kept.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Outputs: clk_o=0, cnt=0, acc=0.
  - If pend is set, transfer P_pend to P_act next cycle and pulse period_ack_o.
  - Go to RUN when enable_i=1 and I(P_act) ≥ 2.
- Period length: at the start of each output period, {carry, acc} ← acc + F(P_act) and L = I(P_act) + carry. Arithmetic is unsigned, acc wraps modulo 2^FRAC_W. The first period after entering RUN uses acc=0.
- Waveform: within an output period, clk_o=1 for the first floor(L/2) cycles and clk_o=0 for the remaining ceil(L/2) cycles.
- Period boundary (cnt==L-1), in RUN:
  - If pend is set, transfer P_pend to P_act and pulse period_ack_o. The new value governs the next period.
  - If the resulting I(P_act) < 2, go to IDLE.
- enable_i=0 in RUN: go to DRAIN. DRAIN finishes the current output period, then enters IDLE at the boundary, so no truncated high or low phase appears. If enable_i returns to 1 during DRAIN, return to RUN with no gap.
- soft_reset_i: on the next edge, go to IDLE and clear P_pend, pend, P_act, acc, cnt and all outputs. It has priority over every other event, including a simultaneous period_wen_i, which is dropped.
- Simultaneous events:
  - A write in the same cycle as a boundary is not taken at that boundary. It applies at the following boundary.
  - A write in IDLE becomes active the next cycle.

## Timing
- Reset values: clk_o=0, running_o=0, period_o=0, period_ack_o=0, state=IDLE.
- Write-to-run latency from IDLE: write at cycle t gives period_o and period_ack_o at t+1. With enable_i high, running_o and clk_o rise at t+2, where clk_o is the first high cycle.
- enable_i asserted in IDLE with a valid P_act: running_o and clk_o rise 1 cycle later.
- All latencies are counted in cycles with cke_i=1.
- The DRAIN exit deasserts running_o on the cycle after the final low cycle of the period.

## Structure
- Package iob_nco_gen_pkg holds:
  - state encodings IDLE/RUN/DRAIN;
  - localparams INT_W = PERIOD_W-FRAC_W and MIN_INT = 2;
  - the period-field extraction helpers.
- Sub-module iob_nco_gen_acc: fractional accumulator, taking F, a step strobe and clear, and producing carry and acc.
- Storage registers use the library iob_reg_cear_r.

## Test plan
- Period 0x0400 (I=4, F=0), enable=1 → clk_o pattern 1,1,0,0 repeating; running_o=1; period_ack_o exactly one pulse.
- Period 0x0280 (2.5) → lengths 2,3,2,3…. Over 100 output periods, 250 input cycles exactly. High phase is 1 cycle per period.
- Running at 0x0400, write 0x0600 mid-period → current period completes at 4 cycles, ack at the boundary, next periods are 6 cycles with a 3/3 duty.
- enable_i dropped at cycle 1 of a 6-cycle period → remaining 5 cycles complete, then running_o=0 and clk_o stays 0.
- soft_reset_i during a high phase → clk_o=0, period_o=0, state IDLE on the next cycle. A simultaneous write is ignored, so period_o stays 0.
- Writes of 0x0100 or 0x0080 (I<2) with enable=1 → running_o stays 0. Holding cke_i=0 for 5 cycles mid-run freezes clk_o and cnt, and the period resumes unchanged afterwards.

Source files
------------

// File: rtl/iob_nco_gen_pkg.sv
// Shared definitions for the NCO generator: state codes,
// default widths and period-word field helpers.
package iob_nco_gen_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam int PERIOD_W_DEF = 16;
   localparam int FRAC_W_DEF   = 8;
   localparam int INT_W        = PERIOD_W_DEF - FRAC_W_DEF;
   localparam int unsigned MIN_INT = 2;

   function automatic logic [31:0] int_part(
      input logic [31:0] p,
      input int unsigned fw
   );
      return p >> fw;
   endfunction

   function automatic logic [31:0] frac_part(
      input logic [31:0] p,
      input int unsigned fw
   );
      return p & ((32'd1 << fw) - 32'd1);
   endfunction

endpackage

// File: rtl/iob_nco_gen_if.sv
// Control/status bundle between the period synchroniser side
// and the NCO generator core.
interface iob_nco_gen_if #(
   parameter int PERIOD_W = 16
);
   logic                cke_i;
   logic                soft_reset_i;
   logic                enable_i;
   logic [PERIOD_W-1:0] period_wdata_i;
   logic                period_wen_i;
   logic                clk_o;
   logic                running_o;
   logic [PERIOD_W-1:0] period_o;
   logic                period_ack_o;

   modport master (
      output cke_i, soft_reset_i, enable_i,
      output period_wdata_i, period_wen_i,
      input  clk_o, running_o, period_o, period_ack_o
   );

   modport slave (
      input  cke_i, soft_reset_i, enable_i,
      input  period_wdata_i, period_wen_i,
      output clk_o, running_o, period_o, period_ack_o
   );
endinterface

// File: rtl/iob_nco_gen_acc.sv
// Fractional phase accumulator; carry stretches the period
// that is starting when step is high.
module iob_nco_gen_acc #(
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              cke,
   input  logic              clr,
   input  logic              step,
   input  logic [FRAC_W-1:0] frac,
   output logic              carry,
   output logic [FRAC_W-1:0] acc
);
   logic [FRAC_W:0] sum;

   assign sum   = {1'b0, acc} + {1'b0, frac};
   assign carry = sum[FRAC_W];

   iob_reg_cear_r #(
      .DATA_W (FRAC_W)
   ) acc_reg (
      .clk  (clk),
      .arst (arst),
      .cke  (cke),
      .rst  (clr),
      .en   (step),
      .d    (sum[FRAC_W-1:0]),
      .q    (acc)
   );
endmodule

// File: rtl/iob_reg_cear_r.sv
// Library register: clock enable, async reset, sync reset,
// load enable.
module iob_reg_cear_r #(
   parameter int                DATA_W  = 1,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              cke,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         q <= RST_VAL;
      end else if (cke) begin
         if (rst) begin
            q <= RST_VAL;
         end else if (en) begin
            q <= d;
         end
      end
   end
endmodule

// File: rtl/iob_nco_gen.sv
// NCO core: turns fixed-point period words into a divided
// clock with fractional stretching and glitch-free stop.
module iob_nco_gen
   import iob_nco_gen_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF,
   parameter int FRAC_W   = FRAC_W_DEF
) (
   input logic          clk_i,
   input logic          arst_i,
   iob_nco_gen_if.slave io
);
   localparam int IW = PERIOD_W - FRAC_W;
   localparam int CW = IW + 1;

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       len;
   logic [CW-1:0]       len_new;
   logic [CW-1:0]       cnt_inc;
   logic                clk_q;
   logic [PERIOD_W-1:0] p_pend;
   logic [PERIOD_W-1:0] p_act;
   logic [PERIOD_W-1:0] p_act_d;
   logic [PERIOD_W-1:0] p_src;
   logic                pend;
   logic                pend_d;
   logic                ack;
   logic                idle;
   logic                bnd;
   logic                take_idle;
   logic                take_bnd;
   logic                p_act_en;
   logic [IW-1:0]       i_src;
   logic [FRAC_W-1:0]   f_src;
   logic                carry;
   logic [FRAC_W-1:0]   acc;
   logic                cont;
   logic                start;
   logic                step;
   logic                clr;

   assign idle      = (state == IDLE);
   assign bnd       = !idle && (cnt == len - 1'b1);
   assign take_idle = idle && (io.period_wen_i || pend);
   assign take_bnd  = bnd && pend;
   assign p_act_en  = take_idle || take_bnd;

   // In IDLE a fresh write bypasses the pending slot
   assign p_act_d = (idle && io.period_wen_i) ?
                    io.period_wdata_i : p_pend;
   assign pend_d  = (io.period_wen_i && !idle) ||
                    (pend && !p_act_en);

   assign p_src = take_bnd ? p_pend : p_act;
   assign i_src = IW'(int_part(32'(p_src), FRAC_W));
   assign f_src = FRAC_W'(frac_part(32'(p_src), FRAC_W));

   assign cont    = io.enable_i && (32'(i_src) >= MIN_INT);
   assign start   = idle && !take_idle && cont;
   assign step    = start || (bnd && cont);
   assign clr     = io.soft_reset_i || (bnd && !cont);
   assign len_new = CW'(i_src) + CW'(carry);
   assign cnt_inc = cnt + 1'b1;

   iob_reg_cear_r #(.DATA_W(PERIOD_W)) pend_val_reg (
      .clk  (clk_i),
      .arst (arst_i),
      .cke  (io.cke_i),
      .rst  (io.soft_reset_i),
      .en   (io.period_wen_i),
      .d    (io.period_wdata_i),
      .q    (p_pend)
   );

   iob_reg_cear_r #(.DATA_W(1)) pend_flag_reg (
      .clk  (clk_i),
      .arst (arst_i),
      .cke  (io.cke_i),
      .rst  (io.soft_reset_i),
      .en   (1'b1),
      .d    (pend_d),
      .q    (pend)
   );

   iob_reg_cear_r #(.DATA_W(PERIOD_W)) act_reg (
      .clk  (clk_i),
      .arst (arst_i),
      .cke  (io.cke_i),
      .rst  (io.soft_reset_i),
      .en   (p_act_en),
      .d    (p_act_d),
      .q    (p_act)
   );

   iob_reg_cear_r #(.DATA_W(1)) ack_reg (
      .clk  (clk_i),
      .arst (arst_i),
      .cke  (io.cke_i),
      .rst  (io.soft_reset_i),
      .en   (1'b1),
      .d    (p_act_en),
      .q    (ack)
   );

   iob_nco_gen_acc #(.FRAC_W(FRAC_W)) acc_u (
      .clk   (clk_i),
      .arst  (arst_i),
      .cke   (io.cke_i),
      .clr   (clr),
      .step  (step),
      .frac  (f_src),
      .carry (carry),
      .acc   (acc)
   );

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= IDLE;
         cnt   <= '0;
         len   <= '0;
         clk_q <= 1'b0;
      end else if (io.cke_i) begin
         if (io.soft_reset_i) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            clk_q <= 1'b0;
         end else if (step) begin
            state <= RUN;
            cnt   <= '0;
            len   <= len_new;
            clk_q <= 1'b1;
         end else if (idle || bnd) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            clk_q <= 1'b0;
         end else begin
            state <= io.enable_i ? RUN : DRAIN;
            cnt   <= cnt_inc;
            clk_q <= (cnt_inc < (len >> 1));
         end
      end
   end

   // Leaving RUN always clears the phase, so IDLE sees acc == 0
   always @(posedge clk_i) begin
      if (!arst_i) begin
         assert (!idle || acc == '0);
      end
   end

   assign io.clk_o        = clk_q;
   assign io.running_o    = !idle;
   assign io.period_o     = p_act;
   assign io.period_ack_o = ack;
endmodule

// File: tb/tb_iob_nco_gen.sv
// Directed bench for iob_nco_gen with hand-computed waveforms.
module tb_iob_nco_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          total = 0;
   int          bad = 0;
   logic [15:0] pat;
   int          acks;
   int          rises;
   int          highs;
   logic        prev;

   iob_nco_gen_if #(.PERIOD_W(16)) bus ();

   iob_nco_gen #(
      .PERIOD_W (16),
      .FRAC_W   (8)
   ) dut (
      .clk_i  (clk),
      .arst_i (rst),
      .io     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] v);
      bus.period_wdata_i = v;
      bus.period_wen_i   = 1'b1;
      tick();
      bus.period_wen_i   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1);
   end

   initial begin
      bus.cke_i          = 1'b1;
      bus.soft_reset_i   = 1'b0;
      bus.enable_i       = 1'b0;
      bus.period_wdata_i = '0;
      bus.period_wen_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_clk", bus.clk_o, 0);
      check("rst_run", bus.running_o, 0);
      check("rst_per", bus.period_o, 0);
      check("rst_ack", bus.period_ack_o, 0);

      // 4-cycle period, 2/2 duty
      bus.enable_i = 1'b1;
      wr(16'h0400);
      check("w4_ack", bus.period_ack_o, 1);
      check("w4_per", bus.period_o, 16'h0400);
      check("w4_run0", bus.running_o, 0);
      check("w4_clk0", bus.clk_o, 0);
      tick();
      check("w4_run1", bus.running_o, 1);
      check("w4_clk1", bus.clk_o, 1);
      check("w4_ack0", bus.period_ack_o, 0);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         pat = {pat[14:0], bus.clk_o};
         if (i < 7) tick();
      end
      check("w4_pat", pat, 16'h00CC);

      // switch to 6 mid-period
      tick();
      tick();
      wr(16'h0600);
      check("w6_noack", bus.period_ack_o, 0);
      check("w6_oldper", bus.period_o, 16'h0400);
      tick();
      check("w6_lastlow", bus.clk_o, 0);
      tick();
      check("w6_ack", bus.period_ack_o, 1);
      check("w6_per", bus.period_o, 16'h0600);
      pat  = '0;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         pat  = {pat[14:0], bus.clk_o};
         acks += int'(bus.period_ack_o);
         if (i < 11) tick();
      end
      check("w6_pat", pat, 16'h0E38);
      check("w6_acks", acks, 1);

      // drop enable at cnt==1 of a 6-cycle period
      tick();
      tick();
      bus.enable_i = 1'b0;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_run", bus.running_o, 1);
         pat = {pat[14:0], bus.clk_o};
      end
      check("drain_pat", pat, 16'h0008);
      tick();
      check("drain_end_run", bus.running_o, 0);
      check("drain_end_clk", bus.clk_o, 0);
      tick();
      check("drain_idle_clk", bus.clk_o, 0);

      // 2.5: 100 periods in 250 cycles
      bus.enable_i = 1'b1;
      wr(16'h0280);
      check("f_ack", bus.period_ack_o, 1);
      tick();
      check("f_clk1", bus.clk_o, 1);
      rises = 0;
      highs = 0;
      prev  = bus.clk_o;
      repeat (250) begin
         tick();
         if (bus.clk_o && !prev) rises++;
         highs += int'(bus.clk_o);
         prev = bus.clk_o;
      end
      check("f_rises", rises, 100);
      check("f_highs", highs, 100);
      check("sr_pre_high", bus.clk_o, 1);

      // soft reset wins over a simultaneous write
      bus.soft_reset_i   = 1'b1;
      bus.period_wdata_i = 16'h0500;
      bus.period_wen_i   = 1'b1;
      tick();
      bus.soft_reset_i   = 1'b0;
      bus.period_wen_i   = 1'b0;
      check("sr_clk", bus.clk_o, 0);
      check("sr_per", bus.period_o, 0);
      check("sr_run", bus.running_o, 0);
      check("sr_ack", bus.period_ack_o, 0);
      tick();
      check("sr_per2", bus.period_o, 0);
      check("sr_run2", bus.running_o, 0);
      check("sr_ack2", bus.period_ack_o, 0);

      // integer part below 2 never runs
      wr(16'h0100);
      check("lo1_per", bus.period_o, 16'h0100);
      check("lo1_ack", bus.period_ack_o, 1);
      tick();
      check("lo1_run_a", bus.running_o, 0);
      tick();
      check("lo1_run_b", bus.running_o, 0);
      wr(16'h0080);
      check("lo0_per", bus.period_o, 16'h0080);
      tick();
      tick();
      check("lo0_run", bus.running_o, 0);
      check("lo0_clk", bus.clk_o, 0);

      // clock-enable freeze mid-period
      wr(16'h0600);
      check("ck_ack", bus.period_ack_o, 1);
      tick();
      check("ck_run", bus.running_o, 1);
      check("ck_clk", bus.clk_o, 1);
      tick();
      bus.cke_i = 1'b0;
      repeat (5) begin
         tick();
         check("ck_frz", bus.clk_o, 1);
      end
      bus.cke_i = 1'b1;
      pat = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pat = {pat[14:0], bus.clk_o};
      end
      check("ck_resume", pat, 16'h0011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
